adpll_lock_controller: RTL

Sequences one NetworkADPLL node through start-up, acquisition, tracking and lock. It gates the node's phase accumulator and schedules the loop-filter gains (kp/ki). It also schedules the four error-combiner weights from the node's own phase error. One instance sits beside each network node in the fpga_clk_i domain.

---
 rtl/adpll_ctrl_pkg.sv | 43 ++++
 rtl/adpll_lock_controller_strobe.sv | 50 +++++
 rtl/adpll_lock_controller.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/adpll_ctrl_pkg.sv
// adpll_ctrl_pkg
//   Shared definitions for the NetworkADPLL lock controller: the 3-bit state
//   encoding, default gain / weight / threshold / count constants, and a
//   saturating two's-complement absolute-value helper.
//   Optional feature macro used by the controller: NADPLL_NEIGHBOUR_GATE_EN.
package adpll_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ACQUIRE = 3'd1,
      ST_TRACK   = 3'd2,
      ST_LOCKED  = 3'd3,
      ST_FAULT   = 3'd4
   } adpll_state_e;

   localparam logic [2:0]  DEF_KP_ACQ        = 3'b100;
   localparam logic [3:0]  DEF_KI_ACQ        = 4'b0010;
   localparam logic [2:0]  DEF_KP_TRK        = 3'b010;
   localparam logic [3:0]  DEF_KI_TRK        = 4'b0001;
   localparam logic [3:0]  DEF_W_PRI         = 4'd2;
   localparam logic [3:0]  DEF_W_NET         = 4'd1;
   localparam logic [7:0]  DEF_LOCK_THRESH   = 8'd2;
   localparam logic [7:0]  DEF_UNLOCK_THRESH = 8'd6;
   localparam logic [15:0] DEF_LOCK_COUNT    = 16'd64;
   localparam logic [15:0] DEF_UNLOCK_COUNT  = 16'd4;
   localparam logic [15:0] DEF_ACQ_TIMEOUT   = 16'd4096;

   // |e| for a value sign-extended from 'width' bits into 32. The most
   // negative 'width'-bit value has no positive twin, so it saturates to
   // 2^(width-1)-1 instead of wrapping back to itself.
   function automatic logic [31:0] abs_sat(input logic signed [31:0] e,
                                           input int unsigned width);
      logic signed [31:0] most_neg;
      most_neg = -(32'sd1 <<< (width - 1));
      if (e == most_neg)
         return (32'd1 << (width - 1)) - 32'd1;
      else if (e < 32'sd0)
         return 32'(-e);
      else
         return 32'(e);
   endfunction

endpackage

// File: rtl/adpll_lock_controller_strobe.sv
// adpll_sample_strobe
//   Brings the node feedback clock gen_div8 into the fpga_clk_i domain,
//   turns each rising edge into a one-cycle strobe and captures the phase
//   error on that strobe. 'valid' marks the cycle the captured sample is
//   presented to the sequencer (one cycle after the strobe).
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   gen_div8         asynchronous feedback clock
//   error            signed phase error (clk domain)
//   strobe           1-cycle pulse, 3 cycles after a gen_div8 rising edge
//   sample, valid    captured error and its qualifying pulse
import adpll_ctrl_pkg::*;

module adpll_sample_strobe #(
   parameter int PDET_WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         gen_div8,
   input  logic signed [PDET_WIDTH-1:0] error,
   output logic                         strobe,
   output logic signed [PDET_WIDTH-1:0] sample,
   output logic                         valid
);

   logic sync1, sync2, sync3;
   logic rise;

   assign rise = sync2 & ~sync3;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         sync3  <= 1'b0;
         strobe <= 1'b0;
         sample <= '0;
         valid  <= 1'b0;
      end else begin
         sync1  <= gen_div8;
         sync2  <= sync1;
         sync3  <= sync2;
         strobe <= rise;
         valid  <= strobe;
         if (strobe)
            sample <= error;
      end
   end

endmodule

// File: rtl/adpll_lock_controller.sv
// adpll_lock_controller
//   Start-up / acquisition / tracking / lock sequencer for one NetworkADPLL
//   node. Gates the phase accumulator, schedules loop-filter gains and the
//   four error-combiner weights. All outputs are registered and decoded from
//   the next state, so they change on the same edge as state_o.
// Ports:
//   fpga_clk_i, reset_i     clock, synchronous active-high reset
//   start_i, stop_i         level controls (stop has priority)
//   gen_div8_i              asynchronous node feedback clock (sample rate)
//   error_i                 signed local phase error
//   neighbour_locked_i      [0] right, [1] below neighbour locked
//   enable_o, kp_o, ki_o    accumulator enable and loop gains
//   weight_*_o              combiner weights
//   locked_o, fault_o       status
//   state_o                 current state encoding
// Optional feature: define NADPLL_NEIGHBOUR_GATE_EN to zero the right/below
// weights in TRACK/LOCKED while the corresponding neighbour is not locked.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | accumulator off, waiting for start
//   ACQUIRE | high gains, left/above prioritised, lock and timeout counted
//   TRACK   | low gains, all weights equal, confirming lock
//   LOCKED  | as TRACK with locked_o, watching for sustained loss
//   FAULT   | acquisition timed out, held until stop or reset
import adpll_ctrl_pkg::*;

module adpll_lock_controller #(
   parameter int                       PDET_WIDTH    = 8,
   parameter int                       KP_WIDTH      = 3,
   parameter int                       KI_WIDTH      = 4,
   parameter int                       WEIGHT_WIDTH  = 4,
   parameter int                       CNT_WIDTH     = 16,
   parameter logic [KP_WIDTH-1:0]      KP_ACQ        = DEF_KP_ACQ,
   parameter logic [KI_WIDTH-1:0]      KI_ACQ        = DEF_KI_ACQ,
   parameter logic [KP_WIDTH-1:0]      KP_TRK        = DEF_KP_TRK,
   parameter logic [KI_WIDTH-1:0]      KI_TRK        = DEF_KI_TRK,
   parameter logic [WEIGHT_WIDTH-1:0]  W_PRI         = DEF_W_PRI,
   parameter logic [WEIGHT_WIDTH-1:0]  W_NET         = DEF_W_NET,
   parameter logic [PDET_WIDTH-1:0]    LOCK_THRESH   = DEF_LOCK_THRESH,
   parameter logic [PDET_WIDTH-1:0]    UNLOCK_THRESH = DEF_UNLOCK_THRESH,
   parameter logic [CNT_WIDTH-1:0]     LOCK_COUNT    = DEF_LOCK_COUNT,
   parameter logic [CNT_WIDTH-1:0]     UNLOCK_COUNT  = DEF_UNLOCK_COUNT,
   parameter logic [CNT_WIDTH-1:0]     ACQ_TIMEOUT   = DEF_ACQ_TIMEOUT
) (
   input  logic                         fpga_clk_i,
   input  logic                         reset_i,
   input  logic                         start_i,
   input  logic                         stop_i,
   input  logic                         gen_div8_i,
   input  logic signed [PDET_WIDTH-1:0] error_i,
   input  logic [1:0]                   neighbour_locked_i,
   output logic                         enable_o,
   output logic [KP_WIDTH-1:0]          kp_o,
   output logic [KI_WIDTH-1:0]          ki_o,
   output logic [WEIGHT_WIDTH-1:0]      weight_left_o,
   output logic [WEIGHT_WIDTH-1:0]      weight_above_o,
   output logic [WEIGHT_WIDTH-1:0]      weight_right_o,
   output logic [WEIGHT_WIDTH-1:0]      weight_below_o,
   output logic                         locked_o,
   output logic                         fault_o,
   output logic [2:0]                   state_o
);

   localparam logic [2:0] S_IDLE    = 3'(ST_IDLE);
   localparam logic [2:0] S_ACQUIRE = 3'(ST_ACQUIRE);
   localparam logic [2:0] S_TRACK   = 3'(ST_TRACK);
   localparam logic [2:0] S_LOCKED  = 3'(ST_LOCKED);
   localparam logic [2:0] S_FAULT   = 3'(ST_FAULT);

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
      return (&c) ? c : c + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   endfunction

   // ---------------------------------------------------------------- sampling
   logic                         strobe;
   logic signed [PDET_WIDTH-1:0] sample;
   logic                         valid;

   adpll_sample_strobe #(
      .PDET_WIDTH (PDET_WIDTH)
   ) u_strobe (
      .clk      (fpga_clk_i),
      .reset    (reset_i),
      .gen_div8 (gen_div8_i),
      .error    (error_i),
      .strobe   (strobe),
      .sample   (sample),
      .valid    (valid)
   );

   logic [31:0] abs_err;
   logic        in_win;
   logic        out_win;

   assign abs_err = abs_sat(32'(sample), PDET_WIDTH);
   assign in_win  = abs_err <= 32'(LOCK_THRESH);
   assign out_win = abs_err >  32'(UNLOCK_THRESH);

   // -------------------------------------------------------------------- FSM
   logic [2:0]           state, state_n;
   logic [CNT_WIDTH-1:0] in_cnt, in_cnt_n;
   logic [CNT_WIDTH-1:0] out_cnt, out_cnt_n;
   logic [CNT_WIDTH-1:0] to_cnt, to_cnt_n;

   always_comb begin
      state_n   = state;
      in_cnt_n  = in_cnt;
      out_cnt_n = out_cnt;
      to_cnt_n  = to_cnt;

      if (stop_i) begin
         state_n   = S_IDLE;
         in_cnt_n  = '0;
         out_cnt_n = '0;
         to_cnt_n  = '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_i) begin
                  state_n   = S_ACQUIRE;
                  in_cnt_n  = '0;
                  out_cnt_n = '0;
                  to_cnt_n  = '0;
               end
            end

            S_ACQUIRE: begin
               if (valid) begin
                  in_cnt_n = in_win ? sat_inc(in_cnt) : '0;
                  to_cnt_n = sat_inc(to_cnt);
                  // Lock is checked first so a simultaneous timeout loses.
                  if (in_cnt_n >= LOCK_COUNT) begin
                     state_n   = S_TRACK;
                     in_cnt_n  = '0;
                     out_cnt_n = '0;
                     to_cnt_n  = '0;
                  end else if (to_cnt_n >= ACQ_TIMEOUT) begin
                     state_n = S_FAULT;
                  end
               end
            end

            S_TRACK: begin
               if (valid) begin
                  if (out_win) begin
                     state_n   = S_ACQUIRE;
                     in_cnt_n  = '0;
                     out_cnt_n = '0;
                     to_cnt_n  = '0;
                  end else begin
                     in_cnt_n = in_win ? sat_inc(in_cnt) : '0;
                     if (in_cnt_n >= LOCK_COUNT) begin
                        state_n   = S_LOCKED;
                        in_cnt_n  = '0;
                        out_cnt_n = '0;
                     end
                  end
               end
            end

            S_LOCKED: begin
               if (valid) begin
                  out_cnt_n = out_win ? sat_inc(out_cnt) : '0;
                  if (out_cnt_n >= UNLOCK_COUNT) begin
                     state_n   = S_ACQUIRE;
                     in_cnt_n  = '0;
                     out_cnt_n = '0;
                     to_cnt_n  = '0;
                  end
               end
            end

            S_FAULT: begin
               state_n = S_FAULT;
            end

            default: begin
               state_n   = S_IDLE;
               in_cnt_n  = '0;
               out_cnt_n = '0;
               to_cnt_n  = '0;
            end
         endcase
      end
   end

   // ----------------------------------------------------------- output decode
   logic                    enable_n, locked_n, fault_n;
   logic [KP_WIDTH-1:0]     kp_n;
   logic [KI_WIDTH-1:0]     ki_n;
   logic [WEIGHT_WIDTH-1:0] w_left_n, w_above_n, w_right_n, w_below_n;
   logic [WEIGHT_WIDTH-1:0] w_right_net, w_below_net;

`ifdef NADPLL_NEIGHBOUR_GATE_EN
   assign w_right_net = neighbour_locked_i[0] ? W_NET : '0;
   assign w_below_net = neighbour_locked_i[1] ? W_NET : '0;
`else
   logic unused_neighbour;
   assign unused_neighbour = ^neighbour_locked_i;
   assign w_right_net      = W_NET;
   assign w_below_net      = W_NET;
`endif

   always_comb begin
      enable_n  = 1'b0;
      locked_n  = 1'b0;
      fault_n   = 1'b0;
      kp_n      = KP_ACQ;
      ki_n      = KI_ACQ;
      w_left_n  = '0;
      w_above_n = '0;
      w_right_n = '0;
      w_below_n = '0;
      case (state_n)
         S_ACQUIRE: begin
            enable_n  = 1'b1;
            w_left_n  = W_PRI;
            w_above_n = W_PRI;
         end
         S_TRACK, S_LOCKED: begin
            enable_n  = 1'b1;
            locked_n  = (state_n == S_LOCKED);
            kp_n      = KP_TRK;
            ki_n      = KI_TRK;
            w_left_n  = W_NET;
            w_above_n = W_NET;
            w_right_n = w_right_net;
            w_below_n = w_below_net;
         end
         S_FAULT: begin
            fault_n = 1'b1;
         end
         default: ;
      endcase
   end

   // -------------------------------------------------------------- registers
   always_ff @(posedge fpga_clk_i) begin
      if (reset_i) begin
         state          <= S_IDLE;
         in_cnt         <= '0;
         out_cnt        <= '0;
         to_cnt         <= '0;
         enable_o       <= 1'b0;
         locked_o       <= 1'b0;
         fault_o        <= 1'b0;
         kp_o           <= KP_ACQ;
         ki_o           <= KI_ACQ;
         weight_left_o  <= '0;
         weight_above_o <= '0;
         weight_right_o <= '0;
         weight_below_o <= '0;
      end else begin
         state          <= state_n;
         in_cnt         <= in_cnt_n;
         out_cnt        <= out_cnt_n;
         to_cnt         <= to_cnt_n;
         enable_o       <= enable_n;
         locked_o       <= locked_n;
         fault_o        <= fault_n;
         kp_o           <= kp_n;
         ki_o           <= ki_n;
         weight_left_o  <= w_left_n;
         weight_above_o <= w_above_n;
         weight_right_o <= w_right_n;
         weight_below_o <= w_below_n;
      end
   end

   assign state_o = state;

endmodule
